mult_arbiter: RTL

- Controller that shares one four_bit_multiplier instance between two requesters, e.g. two KEY_INC/SW operand sources or a future HPS-side port.
- Accepts operand pairs over valid/ready handshakes and arbitrates round-robin.
- Sequences the multiplier through clear, enable and wait-for-done, then returns the product to the granted requester.
- A timeout watchdog guards against a multiplier that never asserts done.

---
 rtl/mult_ctrl_pkg.sv | 22 ++
 rtl/mult_arbiter_rr_arb2.sv | 46 ++++
 rtl/mult_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mult_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mult_ctrl_pkg
// Shared definitions for the multiplier-sharing controller:
//   - state_t   : controller FSM states, encoded for the HEX state display
//   - WIDTH_DEF : default operand width (product is 2*WIDTH)
//   - TIMEOUT_DEF / CNT_W : default RUN watchdog limit and its counter width
//                 (the counter covers the full legal TIMEOUT range 2..255)
// -----------------------------------------------------------------------------
package mult_ctrl_pkg;

  localparam int unsigned WIDTH_DEF   = 4;
  localparam int unsigned TIMEOUT_DEF = 64;
  localparam int unsigned CNT_W       = 8;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    LOAD = 4'd1,
    RUN  = 4'd2,
    RESP = 4'd3
  } state_t;

endpackage

// File: rtl/mult_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter, purely combinational. The owner of the
// last_grant register (the controller FSM) decides when it advances.
// Ports:
//   req[1:0]   in  : request lines, bit N = requester N
//   last_grant in  : requester served most recently
//   gnt_valid  out : at least one request is present
//   gnt_id     out : requester that wins this cycle
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // On a tie the requester that was not served last wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    case (req)
      2'b00: begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
      end
      2'b01: begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b0;
      end
      2'b10: begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b1;
      end
      2'b11: begin
        gnt_valid = 1'b1;
        gnt_id    = ~last_grant;
      end
      default: begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
// Shares one sequential multiplier between two requesters. Operand pairs are
// accepted over valid/ready, arbitrated round-robin, the multiplier is cleared
// (LOAD), enabled until done or watchdog expiry (RUN), and the product is
// returned to the granted requester over valid/ready (RESP).
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   reqN_valid/ready/a/b         : operand request channel of requester N
//   rspN_valid/ready/y/err       : result channel of requester N
//                                  (err = aborted by timeout, y forced to 0)
//   mul_rst/ena/a/b, mul_y/done  : control and data of the shared multiplier
//   busy                         : controller is not in IDLE
//   grant_id                     : requester currently or last served
//   state                        : FSM state code (IDLE=0 LOAD=1 RUN=2 RESP=3)
// -----------------------------------------------------------------------------
module mult_arbiter
  import mult_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  output logic                 rsp0_valid,
  input  logic                 rsp0_ready,
  output logic [2*WIDTH-1:0]   rsp0_y,
  output logic                 rsp0_err,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  output logic                 rsp1_valid,
  input  logic                 rsp1_ready,
  output logic [2*WIDTH-1:0]   rsp1_y,
  output logic                 rsp1_err,
  output logic                 mul_rst,
  output logic                 mul_ena,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_y,
  input  logic                 mul_done,
  output logic                 busy,
  output logic                 grant_id,
  output logic [3:0]           state
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t               state_q;
  logic                 last_grant_q;
  logic                 grant_id_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     mul_a_q;
  logic [WIDTH-1:0]     mul_b_q;
  logic                 mul_rst_q;
  logic                 mul_ena_q;
  logic                 busy_q;
  logic                 rsp0_valid_q;
  logic                 rsp1_valid_q;
  logic [2*WIDTH-1:0]   res_q;
  logic                 err_q;

  logic [1:0]           arb_req;
  logic                 gnt_valid;
  logic                 gnt_id;
  logic                 accept0;
  logic                 accept1;
  logic                 rsp_take;
  logic [WIDTH-1:0]     sel_a;
  logic [WIDTH-1:0]     sel_b;

  assign arb_req = {req1_valid, req0_valid};

  rr_arb2 u_arb (
    .req        (arb_req),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  // Accept decode. Ready must answer valid in the same IDLE cycle, so it is
  // decoded from the registered state; rst_n gating keeps it low during reset
  // even while a requester holds valid.
  always_comb begin
    accept0 = 1'b0;
    accept1 = 1'b0;
    if (rst_n && (state_q == IDLE) && gnt_valid) begin
      accept0 = ~gnt_id;
      accept1 = gnt_id;
    end else begin
      accept0 = 1'b0;
      accept1 = 1'b0;
    end
  end

  // Operand source of the winning requester and the response-consume select.
  always_comb begin
    sel_a    = gnt_id ? req1_a : req0_a;
    sel_b    = gnt_id ? req1_b : req0_b;
    rsp_take = grant_id_q ? rsp1_ready : rsp0_ready;
  end

  // Controller FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      cnt_q        <= {CNT_W{1'b0}};
      mul_a_q      <= {WIDTH{1'b0}};
      mul_b_q      <= {WIDTH{1'b0}};
      mul_rst_q    <= 1'b0;
      mul_ena_q    <= 1'b0;
      busy_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      res_q        <= {(2*WIDTH){1'b0}};
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept0 || accept1) begin
            mul_a_q    <= sel_a;
            mul_b_q    <= sel_b;
            grant_id_q <= gnt_id;
            mul_rst_q  <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          mul_rst_q <= 1'b0;
          mul_ena_q <= 1'b1;
          cnt_q     <= {CNT_W{1'b0}};
          state_q   <= RUN;
        end
        RUN: begin
          // done takes priority over a coinciding watchdog expiry
          if (mul_done) begin
            res_q        <= mul_y;
            err_q        <= 1'b0;
            mul_ena_q    <= 1'b0;
            rsp0_valid_q <= ~grant_id_q;
            rsp1_valid_q <= grant_id_q;
            state_q      <= RESP;
          end else if (cnt_q == CNT_LAST) begin
            res_q        <= {(2*WIDTH){1'b0}};
            err_q        <= 1'b1;
            mul_ena_q    <= 1'b0;
            rsp0_valid_q <= ~grant_id_q;
            rsp1_valid_q <= grant_id_q;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_take) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            last_grant_q <= grant_id_q;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          mul_rst_q    <= 1'b0;
          mul_ena_q    <= 1'b0;
          rsp0_valid_q <= 1'b0;
          rsp1_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign req0_ready = accept0;
  assign req1_ready = accept1;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_y     = res_q;
  assign rsp1_y     = res_q;
  assign rsp0_err   = err_q;
  assign rsp1_err   = err_q;
  assign mul_rst    = mul_rst_q;
  assign mul_ena    = mul_ena_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign busy       = busy_q;
  assign grant_id   = grant_id_q;
  assign state      = state_q;

endmodule
